lcd_text_buffer: RTL and testbench

- 32-character display buffer that sits directly upstream of the LCD init/refresh sequencer and serves its 9-bit {RS, data} fetch stream.
- The sequencer drives a 6-bit command/character address; this block answers with the LCD word for that address: line-change command, character with RS=1, or filler.
- Host logic writes characters directly, or hands over a 32-bit value that the block formats into 8 hex ASCII digits at a fixed field position.
- On reset the block clears itself to spaces.

---
 rtl/lcd_text_buffer.sv | 137 +++++++++++++
 tb/tb_lcd_text_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_buffer.sv
// 32-character LCD text buffer serving the {RS, data} fetch stream.
// Ports: clk, rst (sync active-low), address/data_mem fetch, wr_* direct
// write, hex_valid/hex_ready/hex_value hex formatter, busy status.
module lcd_text_buffer #(
  parameter int HEX_BASE  = 24,
  parameter int LOWERCASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  address,
  output logic [8:0]  data_mem,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_char,
  input  logic        hex_valid,
  output logic        hex_ready,
  input  logic [31:0] hex_value,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_HEX
  } state_e;

  localparam logic [4:0] HB = 5'(HEX_BASE % 32);
  // Offset so that nibble 10 lands on 'A' (0x41) or 'a' (0x61).
  localparam logic [7:0] ALPHA_OFS = (LOWERCASE != 0) ? 8'h57 : 8'h37;

  state_e      state_q, state_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic [2:0]  d_q, d_d;
  logic [31:0] val_q, val_d;
  logic [8:0]  data_mem_q, data_mem_d;
  logic [7:0]  mem_q [32];

  logic        we;
  logic [4:0]  waddr;
  logic [7:0]  wdata;
  logic [3:0]  nib;
  logic [7:0]  asc;
  logic [4:0]  idx_l1, idx_l2;

  assign data_mem  = data_mem_q;
  assign hex_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  // Digit d comes from bits [31-4d -: 4]; ~d_q is 7-d.
  assign nib = val_q[{~d_q, 2'b00} +: 4];
  assign asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                             : (ALPHA_OFS + {4'h0, nib});

  // Low 5 bits suffice: line 2 indices wrap mod 32 to the right slot.
  assign idx_l1 = address[4:0] - 5'd5;
  assign idx_l2 = address[4:0] - 5'd6;

  always_comb begin
    data_mem_d = 9'h000;
    unique case (1'b1)
      (address >= 6'd5 && address <= 6'd20):
        data_mem_d = {1'b1, mem_q[idx_l1]};
      (address == 6'd21):
        data_mem_d = 9'h0C0;
      (address >= 6'd22 && address <= 6'd37):
        data_mem_d = {1'b1, mem_q[idx_l2]};
      default:
        data_mem_d = 9'h000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    d_d       = d_q;
    val_d     = val_q;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    unique case (state_q)
      S_CLEAR: begin
        we        = 1'b1;
        waddr     = clr_idx_q;
        wdata     = 8'h20;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (wr_en) begin
          we    = 1'b1;
          waddr = wr_addr;
          wdata = wr_char;
        end
        if (hex_valid) begin
          val_d   = hex_value;
          d_d     = 3'd0;
          state_d = S_HEX;
        end
      end
      S_HEX: begin
        we = 1'b1;
        if (wr_en) begin
          // Direct write owns the port; digit retries next cycle.
          waddr = wr_addr;
          wdata = wr_char;
        end else begin
          waddr = HB + {2'b00, d_q};
          wdata = asc;
          d_d   = d_q + 3'd1;
          if (d_q == 3'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      clr_idx_q  <= '0;
      d_q        <= '0;
      val_q      <= '0;
      data_mem_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      d_q        <= d_d;
      val_q      <= val_d;
      data_mem_q <= data_mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && we) mem_q[waddr] <= wdata;
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed self-checking bench for lcd_text_buffer.
// Runs an uppercase and a lowercase instance on shared stimulus.
module tb_lcd_text_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  address;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_char;
  logic        hex_valid;
  logic [31:0] hex_value;
  logic [8:0]  data_mem, data_mem_lc;
  logic        hex_ready, hex_ready_lc;
  logic        busy, busy_lc;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_text_buffer #(.HEX_BASE(24), .LOWERCASE(0)) dut (
    .clk(clk), .rst(rst), .address(address), .data_mem(data_mem),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .hex_valid(hex_valid), .hex_ready(hex_ready),
    .hex_value(hex_value), .busy(busy)
  );

  lcd_text_buffer #(.HEX_BASE(24), .LOWERCASE(1)) dut_lc (
    .clk(clk), .rst(rst), .address(address), .data_mem(data_mem_lc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .hex_valid(hex_valid), .hex_ready(hex_ready_lc),
    .hex_value(hex_value), .busy(busy_lc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, input logic [8:0] e,
                    input logic [8:0] el);
    address = a;
    step();
    chk($sformatf("rd_%0d", a), {23'd0, data_mem}, {23'd0, e});
    chk($sformatf("rd_lc_%0d", a), {23'd0, data_mem_lc}, {23'd0, el});
  endtask

  task automatic hex_req(input logic [31:0] v);
    hex_value = v;
    hex_valid = 1'b1;
    chk("ready_before_req", {31'd0, hex_ready}, 32'd1);
    step();
    hex_valid = 1'b0;
  endtask

  // Counts busy cycles; optionally injects one direct write.
  task automatic wait_busy(input int stall_at, input logic [4:0] wa,
                           input logic [7:0] wc, output int n);
    n = 0;
    while (busy && n < 80) begin
      chk("ready_low_busy", {31'd0, hex_ready}, 32'd0);
      if (n == stall_at) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_char = wc;
      end
      step();
      wr_en = 1'b0;
      n++;
    end
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    address   = 6'd0;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_char   = 8'd0;
    hex_valid = 1'b0;
    hex_value = 32'd0;

    step();
    step();
    chk("rst_data_mem", {23'd0, data_mem}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ready", {31'd0, hex_ready}, 32'd0);

    rst = 1'b1;
    hex_valid = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("clr_busy_%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("clr_ready_%0d", i), {31'd0, hex_ready}, 32'd0);
      step();
    end
    hex_valid = 1'b0;
    wr_en = 1'b0;
    chk("clr_done_busy", {31'd0, busy}, 32'd0);
    chk("clr_done_ready", {31'd0, hex_ready}, 32'd1);

    for (int a = 5; a <= 20; a++) rd(6'(a), 9'h120, 9'h120);
    for (int a = 22; a <= 37; a++) rd(6'(a), 9'h120, 9'h120);
    rd(6'd21, 9'h0C0, 9'h0C0);
    rd(6'd2, 9'h000, 9'h000);
    rd(6'd40, 9'h000, 9'h000);

    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_char = 8'h48;
    step();
    wr_addr = 5'd16;
    wr_char = 8'h69;
    step();
    wr_en = 1'b0;
    rd(6'd5, 9'h148, 9'h148);
    rd(6'd22, 9'h169, 9'h169);

    address = 6'd5;
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_char = 8'h58;
    step();
    wr_en = 1'b0;
    chk("rw_same_old", {23'd0, data_mem}, 32'h148);
    step();
    chk("rw_same_new", {23'd0, data_mem}, 32'h158);

    hex_req(32'hDEAD_BEEF);
    wait_busy(-1, 5'd0, 8'd0, n);
    chk("hex_busy_cycles", n, 8);
    chk("hex_ready_back", {31'd0, hex_ready}, 32'd1);
    rd(6'd30, 9'h144, 9'h164);
    rd(6'd31, 9'h145, 9'h165);
    rd(6'd32, 9'h141, 9'h161);
    rd(6'd33, 9'h144, 9'h164);
    rd(6'd34, 9'h142, 9'h162);
    rd(6'd35, 9'h145, 9'h165);
    rd(6'd36, 9'h145, 9'h165);
    rd(6'd37, 9'h146, 9'h166);
    rd(6'd29, 9'h120, 9'h120);

    hex_req(32'h0123_4567);
    wait_busy(3, 5'd2, 8'h41, n);
    chk("stall_busy_cycles", n, 9);
    rd(6'd7, 9'h141, 9'h141);
    for (int a = 30; a <= 37; a++)
      rd(6'(a), 9'(9'h130 + a - 30), 9'(9'h130 + a - 30));

    hex_req(32'h0000_00AB);
    wait_busy(-1, 5'd0, 8'd0, n);
    chk("ab_busy_cycles", n, 8);
    for (int a = 30; a <= 35; a++) rd(6'(a), 9'h130, 9'h130);
    rd(6'd36, 9'h141, 9'h161);
    rd(6'd37, 9'h142, 9'h162);

    hex_req(32'hFFFF_FFFF);
    step();
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_data_mem", {23'd0, data_mem}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_ready", {31'd0, hex_ready}, 32'd0);
    wait_busy(-1, 5'd0, 8'd0, n);
    chk("midrst_clear_cycles", n, 32);
    for (int a = 30; a <= 37; a++) rd(6'(a), 9'h120, 9'h120);
    rd(6'd7, 9'h120, 9'h120);
    step();
    step();
    chk("no_resume_busy", {31'd0, busy}, 32'd0);
    chk("no_resume_ready", {31'd0, hex_ready}, 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
